// File: rtl/mc_port_arbiter_pkg.sv
// Shared types and field widths for the MC port arbiter and its interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_port_arbiter_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int RTNCTL_WIDTH_DEF = 32;

  // MC request/response field widths
  localparam int CMD_W  = 3;
  localparam int SCMD_W = 4;
  localparam int SIZE_W = 2;
  localparam int VADR_W = 48;
  localparam int DATA_W = 64;

  // Width of the requester tag carried in the top bits of rtnctl
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/mc_port_arbiter_if.sv
// Bundle of requester, MC request/response and flush-control signals.
// Latency: n/a (wiring only).
// Backpressure: mc_rq_stall / rsp_stall / req_rdy travel through this bundle.
// Modports: slave = arbiter view, master = environment (requesters + MC) view.
interface mc_port_arbiter_if
  import mc_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ID_WIDTH     = id_width(NUM_REQ),
  parameter int RTNCTL_WIDTH = RTNCTL_WIDTH_DEF
);
  localparam int URW = RTNCTL_WIDTH - ID_WIDTH;

  // requester side
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ*SCMD_W-1:0] req_scmd;
  logic [NUM_REQ*SIZE_W-1:0] req_size;
  logic [NUM_REQ*VADR_W-1:0] req_vadr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*URW-1:0]    req_rtnctl;

  // MC request
  logic                    mc_rq_vld;
  logic [CMD_W-1:0]        mc_rq_cmd;
  logic [SCMD_W-1:0]       mc_rq_scmd;
  logic [SIZE_W-1:0]       mc_rq_size;
  logic [VADR_W-1:0]       mc_rq_vadr;
  logic [DATA_W-1:0]       mc_rq_data;
  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic                    mc_rq_stall;

  // MC response
  logic                    mc_rs_vld;
  logic [CMD_W-1:0]        mc_rs_cmd;
  logic [SCMD_W-1:0]       mc_rs_scmd;
  logic [DATA_W-1:0]       mc_rs_data;
  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic                    mc_rs_stall;

  // requester responses
  logic [NUM_REQ-1:0]      rsp_vld;
  logic [CMD_W-1:0]        rsp_cmd;
  logic [SCMD_W-1:0]       rsp_scmd;
  logic [DATA_W-1:0]       rsp_data;
  logic [URW-1:0]          rsp_rtnctl;
  logic [NUM_REQ-1:0]      rsp_stall;

  // flush control
  logic mc_rq_flush;
  logic mc_rs_flush_cmplt;
  logic flush_req;
  logic flush_done;
  logic busy;

  modport slave (
    input  req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
    output req_rdy,
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    input  mc_rq_stall,
    input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    output mc_rs_stall,
    output rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
    input  rsp_stall,
    output mc_rq_flush, flush_done, busy,
    input  mc_rs_flush_cmplt, flush_req
  );

  modport master (
    output req_vld, req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl,
    input  req_rdy,
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    output mc_rq_stall,
    output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    input  mc_rs_stall,
    input  rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
    output rsp_stall,
    input  mc_rq_flush, flush_done, busy,
    output mc_rs_flush_cmplt, flush_req
  );

endinterface

// File: rtl/mc_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the pointer.
// Latency: grant is combinational; pointer moves on the clock after i_advance.
// Backpressure: pointer holds until the caller signals an accepted transfer.
// Ports: clk, i_reset, i_req (request vector), i_advance (grant consumed),
//        o_grant (one-hot), o_idx (binary index of the grant).
module mc_port_arbiter_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           i_reset,
  input  logic [N-1:0]   i_req,
  input  logic           i_advance,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_cand;
  logic           w_found;

  // Circular search from r_ptr+1; N is a power of two so IDW-bit addition wraps.
  // The last candidate (offset N truncates to 0) is r_ptr itself.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = r_ptr + IDW'(k);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_found         = 1'b1;
      end
    end
  end

  // Reset to N-1 so the first grant after reset goes to requester 0.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_ptr <= IDW'(N - 1);
    else if (i_advance) r_ptr <= o_idx;
  end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one MC request/response port among NUM_REQ requesters, plus a flush sequencer.
// Latency: request accepted in cycle N is on mc_rq_* in N+1; responses route in 0 cycles.
// Backpressure: mc_rq_stall freezes the output register and drops req_rdy; any rsp_stall stalls MC.
// Ports: clk, i_reset (async, active-high), bus (mc_port_arbiter_if.slave).
module mc_port_arbiter
  import mc_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ID_WIDTH     = id_width(NUM_REQ),
  parameter int RTNCTL_WIDTH = RTNCTL_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              i_reset,
  mc_port_arbiter_if.slave  bus
);

  localparam int URW = RTNCTL_WIDTH - ID_WIDTH;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_WIDTH-1:0] w_idx;
  logic [ID_WIDTH-1:0] w_rs_id;
  logic                w_free, w_run, w_en, w_accept;

  fsm_state_t              r_state;
  logic                    r_rq_vld;
  logic [CMD_W-1:0]        r_cmd;
  logic [SCMD_W-1:0]       r_scmd;
  logic [SIZE_W-1:0]       r_size;
  logic [VADR_W-1:0]       r_vadr;
  logic [DATA_W-1:0]       r_data;
  logic [RTNCTL_WIDTH-1:0] r_rtnctl;
  logic                    r_flush, r_flush_done;

  // ---------------- request path ----------------
  assign w_free   = ~r_rq_vld | ~bus.mc_rq_stall;
  assign w_run    = (r_state == ST_RUN);
  // Reset is folded in so req_rdy reads 0 while reset is held.
  assign w_en     = w_free & w_run & ~i_reset;
  assign bus.req_rdy = w_grant & {NUM_REQ{w_en}};
  assign w_accept = |bus.req_rdy;

  mc_port_arbiter_rr_arbiter #(.N(NUM_REQ), .IDW(ID_WIDTH)) u_rr (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_req     (bus.req_vld),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_rq_vld <= 1'b0;
      r_cmd    <= '0;
      r_scmd   <= '0;
      r_size   <= '0;
      r_vadr   <= '0;
      r_data   <= '0;
      r_rtnctl <= '0;
    end else if (w_free) begin
      r_rq_vld <= w_accept;
      if (w_accept) begin
        r_cmd    <= bus.req_cmd[w_idx*CMD_W +: CMD_W];
        r_scmd   <= bus.req_scmd[w_idx*SCMD_W +: SCMD_W];
        r_size   <= bus.req_size[w_idx*SIZE_W +: SIZE_W];
        r_vadr   <= bus.req_vadr[w_idx*VADR_W +: VADR_W];
        r_data   <= bus.req_data[w_idx*DATA_W +: DATA_W];
        r_rtnctl <= {w_idx, bus.req_rtnctl[w_idx*URW +: URW]};
      end
    end
  end

  assign bus.mc_rq_vld    = r_rq_vld;
  assign bus.mc_rq_cmd    = r_cmd;
  assign bus.mc_rq_scmd   = r_scmd;
  assign bus.mc_rq_size   = r_size;
  assign bus.mc_rq_vadr   = r_vadr;
  assign bus.mc_rq_data   = r_data;
  assign bus.mc_rq_rtnctl = r_rtnctl;

  // ---------------- response path ----------------
  assign w_rs_id = bus.mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_WIDTH];

  always_comb begin
    bus.rsp_vld          = '0;
    bus.rsp_vld[w_rs_id] = bus.mc_rs_vld;
  end

  assign bus.rsp_cmd    = bus.mc_rs_cmd;
  assign bus.rsp_scmd   = bus.mc_rs_scmd;
  assign bus.rsp_data   = bus.mc_rs_data;
  assign bus.rsp_rtnctl = bus.mc_rs_rtnctl[URW-1:0];
  // Stall MC whenever any requester stalls, regardless of the response target.
  assign bus.mc_rs_stall = |bus.rsp_stall;

  // ---------------- flush sequencer ----------------
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_flush      <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush      <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN:   if (bus.flush_req) r_state <= ST_DRAIN;
        ST_DRAIN: if (!r_rq_vld) begin
                    r_state <= ST_FLUSH;
                    r_flush <= 1'b1;
                  end
        // A completion arriving during the flush pulse is honoured immediately.
        ST_FLUSH: if (bus.mc_rs_flush_cmplt) begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b1;
                  end else begin
                    r_state <= ST_WAIT;
                  end
        ST_WAIT:  if (bus.mc_rs_flush_cmplt) begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b1;
                  end
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.mc_rq_flush = r_flush;
  assign bus.flush_done  = r_flush_done;
  assign bus.busy        = r_rq_vld | ~w_run;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Self-checking bench for mc_port_arbiter: directed sequences, a response
// routing vector table and a randomized run against a scoreboard model.
module tb_mc_port_arbiter;

  logic clk = 1'b0;
  logic i_reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mc_port_arbiter_if #(.NUM_REQ(4), .ID_WIDTH(2), .RTNCTL_WIDTH(32)) bus ();

  mc_port_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .RTNCTL_WIDTH(32)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
    logic [31:0] rtnctl;
  } txn_t;

  typedef struct {
    logic        rs_vld;
    logic [31:0] rs_rt;
    logic [3:0]  stall;
    logic [3:0]  e_vld;
    logic [29:0] e_rt;
    logic        e_stall;
  } rsp_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a bounded window while a flush is in progress, returning the cycle
  // counts seen. Completion is returned 10 cycles after the flush pulse.
  task automatic run_flush(input int budget, input int second_req_at,
                           output int n_flush, output int n_done,
                           output int vld_at_flush, output int rdy_early,
                           output int flush_cyc, output int done_cyc);
    n_flush = 0; n_done = 0; vld_at_flush = 0; rdy_early = 0;
    flush_cyc = -100; done_cyc = -100;
    for (int c = 0; c < budget; c++) begin
      if (bus.mc_rq_flush === 1'b1) begin
        n_flush++;
        flush_cyc = c;
        if (bus.mc_rq_vld !== 1'b0) vld_at_flush++;
      end
      if (bus.flush_done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      bus.mc_rs_flush_cmplt = (n_flush > 0) && (c == flush_cyc + 10);
      bus.flush_req = (second_req_at >= 0) && (n_flush > 0) && (c == flush_cyc + second_req_at);
      #1;
      if (n_done == 0 && bus.req_rdy !== 4'b0000) rdy_early++;
      tick();
    end
    bus.mc_rs_flush_cmplt = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic set_lane(input int i, input txn_t t);
    bus.req_cmd[i*3 +: 3]     = t.cmd;
    bus.req_scmd[i*4 +: 4]    = t.scmd;
    bus.req_size[i*2 +: 2]    = t.size;
    bus.req_vadr[i*48 +: 48]  = t.vadr;
    bus.req_data[i*64 +: 64]  = t.data;
    bus.req_rtnctl[i*30 +: 30] = t.rtnctl[29:0];
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    rsp_vec_t    tbl[6];
    txn_t        lane[4];
    txn_t        m_cur;
    logic [31:0] rt;
    int nf, nd, vaf, re, fc, dc;
    int m_ptr, gi;
    logic m_vld, free, stall;
    logic [3:0] rv, exp_rdy, rs_stall;
    logic rs_v;
    logic [31:0] rs_rt;

    tbl[0] = '{1'b1, 32'hC000_0005, 4'b0000, 4'b1000, 30'h5,         1'b0};
    tbl[1] = '{1'b1, 32'h0000_0007, 4'b0000, 4'b0001, 30'h7,         1'b0};
    tbl[2] = '{1'b1, 32'h4ABC_DEF0, 4'b0100, 4'b0010, 30'h0ABC_DEF0, 1'b1};
    tbl[3] = '{1'b1, 32'h8000_0001, 4'b0001, 4'b0100, 30'h1,         1'b1};
    tbl[4] = '{1'b0, 32'hC000_0005, 4'b0000, 4'b0000, 30'h5,         1'b0};
    tbl[5] = '{1'b0, 32'h0000_0000, 4'b1111, 4'b0000, 30'h0,         1'b1};

    // ---- initial reset with all requesters active ----
    i_reset = 1'b1;
    bus.req_vld = 4'hF; bus.req_cmd = '0; bus.req_scmd = '0; bus.req_size = '0;
    bus.req_vadr = '0; bus.req_data = '0; bus.req_rtnctl = '0;
    bus.mc_rq_stall = 1'b0; bus.mc_rs_vld = 1'b0; bus.mc_rs_cmd = '0; bus.mc_rs_scmd = '0;
    bus.mc_rs_data = '0; bus.mc_rs_rtnctl = '0; bus.rsp_stall = '0;
    bus.mc_rs_flush_cmplt = 1'b0; bus.flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane[i] = '{3'(i + 1), 4'(i + 8), 2'(i), 48'(i * 256), 64'(64'hA0 + i), 32'(32'h100 + i)};
      set_lane(i, lane[i]);
    end
    #12;
    chk("rst_mc_rq_vld", bus.mc_rq_vld, 0);
    chk("rst_mc_rq_flush", bus.mc_rq_flush, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    chk("rst_req_rdy", bus.req_rdy, 0);
    chk("rst_mc_rq_vadr", bus.mc_rq_vadr, 0);
    i_reset = 1'b0;
    #1;

    // ---- test 1: asynchronous reset in the middle of traffic ----
    repeat (3) tick();
    chk("traffic_vld", bus.mc_rq_vld, 1);
    #2; i_reset = 1'b1;
    #1;
    chk("midrst_mc_rq_vld", bus.mc_rq_vld, 0);
    chk("midrst_flush_done", bus.flush_done, 0);
    chk("midrst_req_rdy", bus.req_rdy, 0);
    #1; i_reset = 1'b0;
    #1;

    // ---- test 2: round-robin order 0,1,2,3,0 with one-cycle lag ----
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_rdy_%0d", k), bus.req_rdy, 4'b0001 << (k % 4));
      tick();
      rt = bus.mc_rq_rtnctl;
      chk($sformatf("rr_vld_%0d", k), bus.mc_rq_vld, 1);
      chk($sformatf("rr_id_%0d", k), rt[31:30], k % 4);
      chk($sformatf("rr_low_%0d", k), rt[29:0], 32'h100 + (k % 4));
      chk($sformatf("rr_vadr_%0d", k), bus.mc_rq_vadr, (k % 4) * 256);
    end

    // ---- test 3: stall holds the output register ----
    bus.req_vld = 4'b0001;
    bus.req_vadr[47:0] = 48'h1000;
    #1;
    chk("stall_pre_rdy", bus.req_rdy, 4'b0001);
    tick();
    bus.mc_rq_stall = 1'b1;
    bus.req_vadr[47:0] = 48'h2000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_rdy_%0d", c), bus.req_rdy, 0);
      tick();
      chk($sformatf("stall_vld_%0d", c), bus.mc_rq_vld, 1);
      chk($sformatf("stall_vadr_%0d", c), bus.mc_rq_vadr, 48'h1000);
    end
    bus.mc_rq_stall = 1'b0;
    #1;
    chk("unstall_rdy", bus.req_rdy, 4'b0001);
    tick();
    chk("unstall_vadr", bus.mc_rq_vadr, 48'h2000);
    bus.req_vld = 4'b0000;
    tick();
    chk("idle_vld_drop", bus.mc_rq_vld, 0);

    // ---- test 4: response routing vector table ----
    bus.mc_rs_data = 64'hDEAD_BEEF_0123_4567;
    for (int v = 0; v < 6; v++) begin
      bus.mc_rs_vld = tbl[v].rs_vld;
      bus.mc_rs_rtnctl = tbl[v].rs_rt;
      bus.rsp_stall = tbl[v].stall;
      #1;
      chk($sformatf("rsp_vld_v%0d", v), bus.rsp_vld, tbl[v].e_vld);
      chk($sformatf("rsp_rtnctl_v%0d", v), bus.rsp_rtnctl, tbl[v].e_rt);
      chk($sformatf("rs_stall_v%0d", v), bus.mc_rs_stall, tbl[v].e_stall);
    end
    chk("rsp_data", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);
    bus.mc_rs_vld = 1'b0; bus.rsp_stall = '0; bus.mc_rs_rtnctl = '0;
    tick();

    // ---- test 5: flush while a stalled request is pending ----
    bus.req_vld = 4'b0010;
    bus.req_vadr[48 +: 48] = 48'h3000;
    #1;
    chk("fl_pre_rdy", bus.req_rdy, 4'b0010);
    tick();
    bus.mc_rq_stall = 1'b1;
    bus.flush_req = 1'b1;
    bus.req_vadr[48 +: 48] = 48'h3100;
    #1;
    chk("fl_req_rdy", bus.req_rdy, 0);
    tick();
    bus.flush_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("drain_rdy_%0d", c), bus.req_rdy, 0);
      chk($sformatf("drain_flush_%0d", c), bus.mc_rq_flush, 0);
      chk($sformatf("drain_busy_%0d", c), bus.busy, 1);
      chk($sformatf("drain_vadr_%0d", c), bus.mc_rq_vadr, 48'h3000);
      tick();
    end
    bus.mc_rq_stall = 1'b0;
    run_flush(40, -1, nf, nd, vaf, re, fc, dc);
    chk("fl_flush_count", nf, 1);
    chk("fl_done_count", nd, 1);
    chk("fl_vld_during_flush", vaf, 0);
    chk("fl_grant_while_flushing", re, 0);
    chk("fl_done_latency", dc - fc, 11);
    #1;
    chk("fl_grants_resume", bus.req_rdy, 4'b0010);

    // ---- test 6: flush_req with an accepted request, then a second flush_req in WAIT ----
    bus.req_vld = 4'b0100;
    bus.req_vadr[96 +: 48] = 48'h4000;
    bus.flush_req = 1'b1;
    #1;
    chk("e6_rdy", bus.req_rdy, 4'b0100);
    tick();
    bus.flush_req = 1'b0;
    bus.req_vld = 4'b0000;
    chk("e6_issued_vld", bus.mc_rq_vld, 1);
    chk("e6_issued_vadr", bus.mc_rq_vadr, 48'h4000);
    chk("e6_no_flush_yet", bus.mc_rq_flush, 0);
    run_flush(40, 3, nf, nd, vaf, re, fc, dc);
    chk("e6_flush_count", nf, 1);
    chk("e6_done_count", nd, 1);
    chk("e6_vld_during_flush", vaf, 0);
    chk("e6_done_latency", dc - fc, 11);
    chk("e6_idle_busy", bus.busy, 0);

    // ---- randomized run against a scoreboard model ----
    i_reset = 1'b1;
    #2; i_reset = 1'b0;
    tick();
    m_vld = 1'b0;
    m_ptr = 3;
    m_cur = '{3'd0, 4'd0, 2'd0, 48'd0, 64'd0, 32'd0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_vld", bus.mc_rq_vld, m_vld);
      chk("rnd_busy", bus.busy, m_vld);
      if (m_vld) begin
        chk("rnd_vadr", bus.mc_rq_vadr, m_cur.vadr);
        chk("rnd_data", bus.mc_rq_data, m_cur.data);
        chk("rnd_rtnctl", bus.mc_rq_rtnctl, m_cur.rtnctl);
        chk("rnd_cmd", {bus.mc_rq_cmd, bus.mc_rq_scmd, bus.mc_rq_size}, {m_cur.cmd, m_cur.scmd, m_cur.size});
      end
      rv = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        lane[i].cmd    = 3'($urandom);
        lane[i].scmd   = 4'($urandom);
        lane[i].size   = 2'($urandom);
        lane[i].vadr   = {16'($urandom), 32'($urandom)};
        lane[i].data   = {32'($urandom), 32'($urandom)};
        lane[i].rtnctl = {2'b00, 30'($urandom)};
        set_lane(i, lane[i]);
      end
      rs_v = 1'($urandom);
      rs_rt = 32'($urandom);
      rs_stall = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      bus.req_vld = rv;
      bus.mc_rq_stall = stall;
      bus.mc_rs_vld = rs_v;
      bus.mc_rs_rtnctl = rs_rt;
      bus.rsp_stall = rs_stall;
      #1;
      free = !m_vld || !stall;
      gi = -1;
      if (free) begin
        for (int k = 1; k <= 4; k++) begin
          if (gi < 0 && rv[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
        end
      end
      exp_rdy = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
      chk("rnd_rdy", bus.req_rdy, exp_rdy);
      chk("rnd_rsp_vld", bus.rsp_vld, rs_v ? (4'b0001 << rs_rt[31:30]) : 4'b0000);
      chk("rnd_rsp_rtnctl", bus.rsp_rtnctl, rs_rt[29:0]);
      chk("rnd_rs_stall", bus.mc_rs_stall, rs_stall != 4'b0000);
      if (free) begin
        m_vld = (gi >= 0);
        if (gi >= 0) begin
          m_cur = lane[gi];
          m_cur.rtnctl = {2'(gi), lane[gi].rtnctl[29:0]};
          m_ptr = gi;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
Shares one memory-controller (MC) request/response port among NUM_REQ personality-internal requesters, such as a load engine, a store engine and a dispatch-driven AEG DMA helper. It sits inside cae_pers between the personality datapath and the MC interface that is currently tied off. Requests are granted round-robin and tagged in the top ID bits of rtnctl, and responses are routed back by that tag. A flush sequencer issues mc_rq_flush on command and reports completion.

Parameters:
NUM_REQ, 4, number of requesters (power of 2, >=2)
ID_WIDTH, 2, log2(NUM_REQ); width of requester tag
RTNCTL_WIDTH, 32, MC rtnctl width; requester-visible rtnctl is RTNCTL_WIDTH-ID_WIDTH bits

Ports:
clk  in  1  personality clock
i_reset  in  1  asynchronous, active-high reset
req_vld  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester accept; transfer when req_vld[i]&req_rdy[i]
req_cmd  in  NUM_REQ*3  MC command, passed through unmodified
req_scmd  in  NUM_REQ*4  MC subcommand
req_size  in  NUM_REQ*2  MC size
req_vadr  in  NUM_REQ*48  virtual address
req_data  in  NUM_REQ*64  write data
req_rtnctl  in  NUM_REQ*(RTNCTL_WIDTH-ID_WIDTH)  requester return control
mc_rq_vld/cmd/scmd/size/vadr/data/rtnctl  out  1/3/4/2/48/64/RTNCTL_WIDTH  MC request
mc_rq_stall  in  1  MC backpressure
mc_rs_vld/cmd/scmd/data/rtnctl  in  1/3/4/64/RTNCTL_WIDTH  MC response
mc_rs_stall  out  1  response backpressure to MC
rsp_vld  out  NUM_REQ  per-requester response valid
rsp_cmd/scmd/data/rtnctl  out  3/4/64/RTNCTL_WIDTH-ID_WIDTH  response fields, broadcast to all requesters
rsp_stall  in  NUM_REQ  per-requester response backpressure
mc_rq_flush  out  1  MC write flush
mc_rs_flush_cmplt  in  1  flush complete
flush_req  in  1  single-cycle flush command
flush_done  out  1  single-cycle flush completion pulse
busy  out  1  request register occupied or FSM not in RUN

Behaviour:
- Reset (asynchronous, i_reset=1): all mc_rq_* = 0, mc_rq_flush=0, flush_done=0, req_rdy=0, RR pointer=NUM_REQ-1, FSM=RUN.
- Request path: a single output register holds mc_rq_*. A request transfers to the MC on any cycle with mc_rq_vld=1 and mc_rq_stall=0.
- While mc_rq_vld=1 and mc_rq_stall=1, all mc_rq_* hold stable.
- Free condition: free = ~mc_rq_vld | ~mc_rq_stall.
- Grant: one-hot, at most one bit set. grant[i] goes to the first requester with req_vld set, searching circularly from pointer+1.
- req_rdy = grant & {NUM_REQ{free & state==RUN}}. req_rdy is a combinational function of req_vld.
- Latency: a request accepted in cycle N appears on mc_rq_* in cycle N+1.
- If no request is accepted while free, mc_rq_vld goes to 0 next cycle.
- mc_rq_rtnctl = {granted index, req_rtnctl[i]}.
- The RR pointer updates to the granted index only on an accepted transfer, so it wraps from NUM_REQ-1 to 0.
- Response path (combinational, zero latency):
  - id = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_WIDTH].
  - rsp_vld[id] = mc_rs_vld; all other rsp_vld bits are 0.
  - rsp_rtnctl = low bits of mc_rs_rtnctl.
  - mc_rs_stall = |rsp_stall (conservative).
- FSM states:
  - RUN: on flush_req -> DRAIN. Grants are disabled from the following cycle. A request accepted in the same cycle as flush_req still completes.
  - DRAIN: stay until mc_rq_vld=0, then -> FLUSH.
  - FLUSH: mc_rq_flush=1 for exactly one cycle -> WAIT.
  - WAIT: on mc_rs_flush_cmplt -> RUN with flush_done=1 for one cycle (registered). mc_rs_flush_cmplt seen in FLUSH is also accepted and produces flush_done the next cycle.
- flush_req outside RUN is ignored.
- Reset mid-flush returns to RUN with no flush_done pulse.
- Simultaneous events:
  - A response arriving during a flush is routed normally.
  - A requester deasserting req_vld while it is granted is legal; the grant re-evaluates in the same cycle.

Decomposition:
- Shared package: ID_WIDTH derivation, the FSM state enum (RUN/DRAIN/FLUSH/WAIT), and MC cmd/size field widths.
- One sub-module: rr_arbiter (req vector, pointer, advance -> one-hot grant), reused by later dispatch arbitration.

Test Plan:
1. Reset mid-traffic: all four requesters busy, pulse i_reset asynchronously -> mc_rq_vld=0, flush_done=0, and the next grant goes to requester 0.
2. Round-robin fairness: req_vld=4'b1111 continuously, mc_rq_stall=0 -> grant order 0,1,2,3,0 over 5 cycles; mc_rq_rtnctl[31:30]=0,1,2,3,0; outputs lag acceptance by 1 cycle.
3. Stall hold: request vadr=0x1000 outstanding, mc_rq_stall=1 for 3 cycles -> mc_rq_* unchanged, req_rdy=0; released on the first unstalled cycle and the next request follows in the following cycle.
4. Response routing: mc_rs_vld=1, mc_rs_rtnctl=0xC0000005 -> rsp_vld=4'b1000, rsp_rtnctl=0x5. Any rsp_stall bit set -> mc_rs_stall=1.
5. Flush: flush_req while a stalled request is pending -> no new grants; mc_rq_flush pulses exactly once after mc_rq_vld=0; mc_rs_flush_cmplt 10 cycles later -> flush_done pulses once and grants resume.
6. Edge cases:
   - flush_req coincides with an accepted request -> that request is issued before mc_rq_flush.
   - A second flush_req during WAIT is ignored, giving exactly one flush_done.
